// File: rtl/int_ctrl.sv
// Trap/interrupt controller: a programmable match timer plus a three-state
// trap sequencer (IDLE -> ISSUE -> HANDLER) that hands a cause to next-PC logic.
module int_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              PCWrite,
  input  logic              illegal_instr,
  input  logic              ecall,
  input  logic              int_ret,
  input  logic              bus_we,
  input  logic [1:0]        bus_addr,
  input  logic [DATA_W-1:0] bus_wdata,
  output logic [DATA_W-1:0] bus_rdata,
  output logic              INT_Signal,
  output logic [2:0]        INT_PEND,
  output logic              EXL_Set
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    HANDLER = 2'd2
  } state_t;

  localparam logic [2:0] CAUSE_NONE    = 3'b000;
  localparam logic [2:0] CAUSE_TIMER   = 3'b001;
  localparam logic [2:0] CAUSE_ILLEGAL = 3'b010;
  localparam logic [2:0] CAUSE_ECALL   = 3'b011;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_CMP    = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam logic [DATA_W-1:0] COUNT_ONE = 1;

  state_t            state;
  logic              tmr_en;
  logic              irq_en;
  logic [DATA_W-1:0] cmp;
  logic [DATA_W-1:0] count;
  logic              timer_pend;

  logic              wr_ctrl;
  logic              wr_cmp;
  logic              wr_count;
  logic              wr_status;
  logic              match;
  logic              accept;
  logic              trap_ret;
  logic              sw_clear;
  logic [2:0]        sel_cause;

  // Fixed priority among trap sources; the timer only competes when unmasked.
  function automatic logic [2:0] select_cause(input logic ill, input logic ec,
                                              input logic pend, input logic irq);
    if (ill)
      return CAUSE_ILLEGAL;
    else if (ec)
      return CAUSE_ECALL;
    else if (pend && irq)
      return CAUSE_TIMER;
    else
      return CAUSE_NONE;
  endfunction

  assign wr_ctrl   = bus_we && (bus_addr == ADDR_CTRL);
  assign wr_cmp    = bus_we && (bus_addr == ADDR_CMP);
  assign wr_count  = bus_we && (bus_addr == ADDR_COUNT);
  assign wr_status = bus_we && (bus_addr == ADDR_STATUS);

  // Match is judged on the pre-write count so a same-cycle COUNT write never hides it.
  assign match     = tmr_en && (cmp != '0) && (count == cmp);
  assign accept    = (state == ISSUE) && PCWrite;
  assign trap_ret  = (state == HANDLER) && int_ret && PCWrite;
  assign sw_clear  = wr_status && bus_wdata[0];
  assign sel_cause = select_cause(illegal_instr, ecall, timer_pend, irq_en);

  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_en     <= 1'b0;
      irq_en     <= 1'b0;
      cmp        <= '0;
      count      <= '0;
      timer_pend <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        tmr_en <= bus_wdata[0];
        irq_en <= bus_wdata[1];
      end
      if (wr_cmp)
        cmp <= bus_wdata;
      if (wr_count)
        count <= bus_wdata;
      else if (match)
        count <= '0;
      else if (tmr_en)
        count <= count + COUNT_ONE;
      // A fresh match always outranks any clear landing on the same edge.
      if (match)
        timer_pend <= 1'b1;
      else if (sw_clear || (accept && (INT_PEND == CAUSE_TIMER)))
        timer_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      INT_Signal <= 1'b0;
      INT_PEND   <= CAUSE_NONE;
      EXL_Set    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_cause != CAUSE_NONE) begin
            state      <= ISSUE;
            INT_Signal <= 1'b1;
            INT_PEND   <= sel_cause;
          end
        end
        ISSUE: begin
          if (accept) begin
            state      <= HANDLER;
            INT_Signal <= 1'b0;
            INT_PEND   <= CAUSE_NONE;
            EXL_Set    <= 1'b1;
          end
        end
        HANDLER: begin
          // Synchronous traps arriving here are dropped, never queued.
          if (trap_ret) begin
            state   <= IDLE;
            EXL_Set <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          INT_Signal <= 1'b0;
          INT_PEND   <= CAUSE_NONE;
          EXL_Set    <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    bus_rdata = '0;
    case (bus_addr)
      ADDR_CTRL: begin
        bus_rdata[0] = tmr_en;
        bus_rdata[1] = irq_en;
      end
      ADDR_CMP:   bus_rdata = cmp;
      ADDR_COUNT: bus_rdata = count;
      ADDR_STATUS: begin
        bus_rdata[0]   = timer_pend;
        bus_rdata[1]   = EXL_Set;
        bus_rdata[4:2] = INT_PEND;
      end
      default: bus_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed scenarios then random traffic, all compared
// cycle by cycle against a behavioural model of the trap controller.
module tb_int_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCWrite;
  logic        illegal_instr;
  logic        ecall;
  logic        int_ret;
  logic        bus_we;
  logic [1:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        INT_Signal;
  logic [2:0]  INT_PEND;
  logic        EXL_Set;

  int errors = 0;
  int checks = 0;

  // Behavioural model state: outputs are modelled directly, phase is implied.
  bit          m_tmr, m_irq, m_pend, m_sig, m_exl;
  logic [31:0] m_cmp, m_count;
  logic [2:0]  m_cause;

  int_ctrl #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .PCWrite(PCWrite), .illegal_instr(illegal_instr),
    .ecall(ecall), .int_ret(int_ret), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .INT_Signal(INT_Signal),
    .INT_PEND(INT_PEND), .EXL_Set(EXL_Set)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_rdata(input logic [1:0] a);
    case (a)
      2'd0:    return {30'd0, m_irq, m_tmr};
      2'd1:    return m_cmp;
      2'd2:    return m_count;
      default: return {27'd0, m_cause, m_exl, m_pend};
    endcase
  endfunction

  task automatic model_step();
    bit          hit, idle, acc, wr;
    logic [2:0]  nc;
    logic [31:0] n_count;
    bit          n_pend;
    if (rst) begin
      m_tmr = 0; m_irq = 0; m_pend = 0; m_sig = 0; m_exl = 0;
      m_cmp = 0; m_count = 0; m_cause = 0;
      return;
    end
    hit  = m_tmr && (m_cmp != 0) && (m_count == m_cmp);
    idle = !m_sig && !m_exl;
    acc  = m_sig && PCWrite;
    nc = 3'd0;
    if (idle) begin
      if (illegal_instr)      nc = 3'd2;
      else if (ecall)         nc = 3'd3;
      else if (m_pend && m_irq) nc = 3'd1;
    end
    wr = bus_we;
    if (wr && bus_addr == 2'd2) n_count = bus_wdata;
    else if (hit)               n_count = 0;
    else if (m_tmr)             n_count = m_count + 32'd1;
    else                        n_count = m_count;
    if (hit) n_pend = 1;
    else if ((wr && bus_addr == 2'd3 && bus_wdata[0]) || (acc && m_cause == 3'd1)) n_pend = 0;
    else n_pend = m_pend;
    if (wr && bus_addr == 2'd0) begin m_tmr = bus_wdata[0]; m_irq = bus_wdata[1]; end
    if (wr && bus_addr == 2'd1) m_cmp = bus_wdata;
    m_count = n_count;
    m_pend  = n_pend;
    if (nc != 0) begin
      m_sig = 1; m_cause = nc;
    end else if (acc) begin
      m_sig = 0; m_exl = 1; m_cause = 0;
    end else if (m_exl && int_ret && PCWrite) begin
      m_exl = 0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("int_signal", {31'd0, INT_Signal}, {31'd0, m_sig});
    check("int_pend",   {29'd0, INT_PEND},   {29'd0, m_cause});
    check("exl_set",    {31'd0, EXL_Set},    {31'd0, m_exl});
    check("rdata",      bus_rdata,           model_rdata(bus_addr));
    check("sig_vs_exl", {31'd0, INT_Signal && EXL_Set}, 32'd0);
  endtask

  task automatic quiet();
    rst = 0; PCWrite = 0; illegal_instr = 0; ecall = 0; int_ret = 0;
    bus_we = 0; bus_addr = 2'd3; bus_wdata = 0;
  endtask

  task automatic do_reset();
    quiet(); rst = 1; tick(); rst = 0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus_we = 1; bus_addr = a; bus_wdata = d; tick(); bus_we = 0; bus_addr = 2'd3;
  endtask

  initial begin
    quiet();
    rst = 1;
    tick();
    check("rst_sig",    {31'd0, INT_Signal}, 32'd0);
    check("rst_status", bus_rdata, 32'd0);
    rst = 0;

    // Illegal-instruction trap, then handler protection against ecall.
    illegal_instr = 1; PCWrite = 1; tick();
    check("ill_sig",  {31'd0, INT_Signal}, 32'd1);
    check("ill_pend", {29'd0, INT_PEND}, 32'd2);
    illegal_instr = 0; tick();
    check("ill_exl", {31'd0, EXL_Set}, 32'd1);
    check("ill_sig_drop", {31'd0, INT_Signal}, 32'd0);
    PCWrite = 0; ecall = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("hnd_no_sig", {31'd0, INT_Signal}, 32'd0);
    end
    ecall = 0; int_ret = 1; PCWrite = 1; tick();
    check("hnd_ret_exl", {31'd0, EXL_Set}, 32'd0);
    int_ret = 0; PCWrite = 0; tick();
    check("ecall_not_replayed", {31'd0, INT_Signal}, 32'd0);

    // Periodic timer with CMP=5: pending every 6 cycles.
    do_reset();
    bus_write(2'd1, 32'd5);
    bus_write(2'd0, 32'd3);
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("per_pend_a", {31'd0, bus_rdata[0]}, {31'd0, i == 6});
    end
    tick();
    check("per_sig",   {31'd0, INT_Signal}, 32'd1);
    check("per_cause", {29'd0, INT_PEND}, 32'd1);
    PCWrite = 1; tick();
    check("per_clr", {31'd0, bus_rdata[0]}, 32'd0);
    int_ret = 1; tick();
    int_ret = 0; PCWrite = 0;
    for (int j = 1; j <= 3; j++) begin
      tick();
      check("per_pend_b", {31'd0, bus_rdata[0]}, {31'd0, j == 3});
    end

    // Stall and priority: ecall beats timer, held while PCWrite=0.
    do_reset();
    bus_write(2'd1, 32'd3);
    bus_write(2'd0, 32'd1);
    for (int i = 0; i < 4; i++) tick();
    check("stl_pend", {31'd0, bus_rdata[0]}, 32'd1);
    bus_we = 1; bus_addr = 2'd0; bus_wdata = 32'd2; ecall = 1; tick();
    bus_we = 0; bus_addr = 2'd3; ecall = 0;
    for (int i = 0; i < 3; i++) begin
      check("stl_hold", {29'd0, INT_PEND}, 32'd3);
      tick();
    end
    check("stl_hold_last", {29'd0, INT_PEND}, 32'd3);
    PCWrite = 1; tick();
    check("stl_timer_kept", {31'd0, bus_rdata[0]}, 32'd1);
    int_ret = 1; tick();
    check("stl_ret_sig", {31'd0, INT_Signal}, 32'd0);
    int_ret = 0; PCWrite = 0; tick();
    check("stl_timer_cause", {29'd0, INT_PEND}, 32'd1);
    PCWrite = 1; tick();
    check("stl_timer_clr", {31'd0, bus_rdata[0]}, 32'd0);
    int_ret = 1; tick();
    int_ret = 0; PCWrite = 0;

    // Reset in the middle of an issued trap.
    ecall = 1; tick();
    ecall = 0; rst = 1; tick(); rst = 0;
    check("rst_mid_sig",    {31'd0, INT_Signal}, 32'd0);
    check("rst_mid_status", bus_rdata, 32'd0);

    // Wrap at all-ones with CMP=0, then STATUS/COUNT writes on match cycles.
    bus_write(2'd0, 32'd1);
    bus_we = 1; bus_addr = 2'd2; bus_wdata = 32'hFFFF_FFFF; tick(); bus_we = 0;
    check("wrap_max", bus_rdata, 32'hFFFF_FFFF);
    tick();
    check("wrap_zero", bus_rdata, 32'd0);
    bus_addr = 2'd3; #1;
    check("wrap_no_pend", {31'd0, bus_rdata[0]}, 32'd0);
    do_reset();
    bus_write(2'd1, 32'd2);
    bus_write(2'd0, 32'd1);
    tick(); tick();
    bus_write(2'd3, 32'd1);
    check("clr_vs_match", {31'd0, bus_rdata[0]}, 32'd1);
    bus_write(2'd3, 32'd1);
    check("clr_plain", {31'd0, bus_rdata[0]}, 32'd0);
    tick();
    bus_we = 1; bus_addr = 2'd2; bus_wdata = 32'd7; tick(); bus_we = 0;
    check("cnt_wr_match_val", bus_rdata, 32'd7);
    bus_addr = 2'd3; #1;
    check("cnt_wr_match_pend", {31'd0, bus_rdata[0]}, 32'd1);

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      rst           = ($urandom_range(0, 149) == 0);
      PCWrite       = ($urandom_range(0, 1) == 1);
      illegal_instr = ($urandom_range(0, 9) == 0);
      ecall         = ($urandom_range(0, 9) == 0);
      int_ret       = ($urandom_range(0, 3) == 0);
      bus_we        = ($urandom_range(0, 5) == 0);
      bus_addr      = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       bus_wdata = $urandom();
        1:       bus_wdata = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        default: bus_wdata = 32'($urandom_range(0, 7));
      endcase
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 SHALL have a single clock and a synchronous, active-high reset.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 PCWrite  input  1  PC update enable; an issued trap is accepted on a clk edge with PCWrite=1.
REQ-005 illegal_instr  input  1  EX-stage illegal-instruction flag.
REQ-006 ecall  input  1  EX-stage ecall flag.
REQ-007 int_ret  input  1  EX-stage trap-return flag (NPCOp = NPC_INT_RET).
REQ-008 bus_we  input  1  register write strobe.
REQ-009 bus_addr  input  2  register select.
REQ-010 bus_wdata  input  32  write data.
REQ-011 bus_rdata  output  32  read data, combinational from bus_addr.
REQ-012 INT_Signal  output  1  trap request to the next-PC logic.
REQ-013 INT_PEND  output  3  trap cause: 3'b000 none, 3'b001 int_timer, 3'b010 int_illegal_instr, 3'b011 int_ecall.
REQ-014 EXL_Set  output  1  exception level; 1 while a handler runs.

Function
REQ-015 SHALL implement the FSM IDLE -> ISSUE -> HANDLER -> IDLE.
REQ-016 IDLE: INT_Signal=0, EXL_Set=0, INT_PEND=000.
REQ-017 IDLE trap selection priority: illegal_instr > ecall > timer (timer_pend=1 and irq_en=1).
REQ-018 IDLE -> ISSUE on any selected source; the cause is latched into INT_PEND on the same edge.
REQ-019 ISSUE: INT_Signal=1 and INT_PEND held stable until the accepting edge; no change to cause while waiting.
REQ-020 ISSUE -> HANDLER on an edge with PCWrite=1: EXL_Set<=1, INT_Signal<=0, INT_PEND<=000; timer_pend cleared if cause was timer.
REQ-021 ISSUE with PCWrite=0: remain in ISSUE indefinitely.
REQ-022 HANDLER: illegal_instr and ecall ignored (dropped); the timer still sets timer_pend.
REQ-023 HANDLER -> IDLE on an edge with int_ret=1 and PCWrite=1: EXL_Set<=0.
REQ-024 A pending trap in IDLE is issued no earlier than the cycle after return (INT_Signal rises 1 cycle after EXL_Set falls).
REQ-025 INT_Signal SHALL never be 1 while EXL_Set=1.
REQ-026 Timer: 32-bit count increments by 1 every cycle while tmr_en=1; count holds while tmr_en=0.
REQ-027 On a cycle where tmr_en=1, cmp!=0 and count==cmp: timer_pend<=1 and count<=0 on the next edge.
REQ-028 cmp=0 SHALL never match.
REQ-029 At count=32'hFFFFFFFF with no match, count wraps to 0.
REQ-030 Register map, addr 0 CTRL: bit0 tmr_en, bit1 irq_en; other bits read 0.
REQ-031 Register map, addr 1 CMP.
REQ-032 Register map, addr 2 COUNT, read/write.
REQ-033 Register map, addr 3 STATUS: bit0 timer_pend, bit1 EXL_Set, bits4:2 current cause.
REQ-034 A write to STATUS with bit0=1 clears timer_pend; other STATUS bits are read-only.
REQ-035 A COUNT write in a match cycle: match is evaluated on the pre-write value, so timer_pend is set, and COUNT takes the written value.
REQ-036 A STATUS clear coinciding with a match: set wins.
REQ-037 A STATUS clear coinciding with trap acceptance: pend=0.

Reset
REQ-038 On rst=1 at an edge: state IDLE, INT_Signal=0, INT_PEND=000, EXL_Set=0, timer_pend=0, CTRL=0, CMP=0, COUNT=0.
REQ-039 A reset asserted in ISSUE or HANDLER SHALL abort the trap with no residual pending.
REQ-040 All outputs SHALL be valid in the cycle after reset deasserts.

Verification
REQ-041 Illegal-instruction trap: illegal_instr=1 in IDLE with PCWrite=1 -> next cycle INT_Signal=1, INT_PEND=010; the following edge gives EXL_Set=1, INT_Signal=0.
REQ-042 Periodic timer: CMP=5, CTRL=3 -> timer_pend at count 5, INT_PEND=001; count restarts at 0 and the period is 6 cycles.
REQ-043 Stall and priority: ecall and timer_pend simultaneously with PCWrite=0 for 4 cycles -> INT_PEND=011 held 4 cycles; the timer is served after int_ret.
REQ-044 Handler protection: ecall during HANDLER -> no INT_Signal; int_ret with PCWrite=1 -> EXL_Set=0; ecall is not replayed.
REQ-045 Reset mid-operation: rst during ISSUE -> INT_Signal=0, INT_PEND=000, STATUS read=0 next cycle.
REQ-046 Boundaries: COUNT write 32'hFFFFFFFF with CMP=0 -> wrap to 0 with no pending; a STATUS clear coinciding with a match -> pend remains 1.
